// File: rtl/shared_mem_xbar.sv
// Banked shared-memory crossbar: NUM_CORES cores onto NUM_BANKS word-interleaved
// single-port banks plus a device window, each target with its own round-robin arbiter.
module shared_mem_xbar #(
    parameter int NUM_CORES      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int GMEM_WORDS     = 1024,
    parameter int NUM_BANKS      = 2,
    parameter int DEV_ADDR_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CORES-1:0]             core_req,
    input  logic [NUM_CORES-1:0]             core_wren,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_write_data,
    output logic [NUM_CORES-1:0]             core_ready,
    output logic [NUM_CORES-1:0]             core_rvalid,
    output logic [NUM_CORES*DATA_WIDTH-1:0]  core_read_data,
    output logic                             device_write_en,
    output logic                             device_read_en,
    output logic [DEV_ADDR_WIDTH-1:0]        device_addr,
    output logic [DATA_WIDTH-1:0]            device_data_out,
    input  logic [DATA_WIDTH-1:0]            device_data_in,
    output logic [$clog2(NUM_CORES)-1:0]     device_core_id
);

    localparam int CW    = $clog2(NUM_CORES);
    localparam int GW    = $clog2(GMEM_WORDS);
    localparam int BB    = $clog2(NUM_BANKS);
    localparam int BSW   = (BB > 0) ? BB : 1;
    localparam int WW    = GW - BB;
    localparam int WPB   = GMEM_WORDS / NUM_BANKS;
    localparam int NT    = NUM_BANKS + 1;
    localparam int DEV_T = NUM_BANKS;

    // Round-robin search from ptr, wrapping modulo NUM_CORES; returns {found, id}.
    function automatic logic [CW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                            input logic [CW-1:0]        ptr);
        logic          found;
        logic [CW-1:0] id;
        logic [CW-1:0] idx;
        int            sum;
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_CORES) sum = sum - NUM_CORES;
            idx = CW'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
        return {found, id};
    endfunction

    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] id);
        return (id == CW'(NUM_CORES - 1)) ? '0 : id + 1'b1;
    endfunction

    logic [NUM_CORES-1:0] is_dev;
    logic [BSW-1:0]       bank_sel  [NUM_CORES];
    logic [WW-1:0]        bank_word [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_decode
        assign is_dev[i] = &core_addr[i*ADDR_WIDTH+DEV_ADDR_WIDTH +: ADDR_WIDTH-DEV_ADDR_WIDTH];
        if (BB > 0) begin : g_bsel
            assign bank_sel[i] = core_addr[i*ADDR_WIDTH +: BSW];
        end else begin : g_nobsel
            assign bank_sel[i] = '0;
        end
        assign bank_word[i] = core_addr[i*ADDR_WIDTH+BB +: WW];
    end

    logic [NUM_CORES-1:0] tgt_req [NT];

    always_comb begin
        for (int t = 0; t < NT; t++) tgt_req[t] = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            tgt_req[DEV_T][i] = core_req[i] && is_dev[i];
            for (int t = 0; t < NUM_BANKS; t++) begin
                tgt_req[t][i] = core_req[i] && !is_dev[i] && (bank_sel[i] == BSW'(t));
            end
        end
    end

    // Stage p0: arbitration and winner mux, all combinational from requests and pointers.
    logic [CW-1:0]         ptr          [NT];
    logic [NT-1:0]         gnt_vld_p0;
    logic [CW-1:0]         gnt_id_p0    [NT];
    logic [NT-1:0]         win_wren_p0;
    logic [DATA_WIDTH-1:0] win_wdata_p0 [NT];
    logic [WW-1:0]         win_word_p0  [NT];

    always_comb begin
        logic [CW:0] pick;
        pick = '0;
        for (int t = 0; t < NT; t++) begin
            pick            = rr_pick(tgt_req[t], ptr[t]);
            gnt_vld_p0[t]   = pick[CW] && reset_n;
            gnt_id_p0[t]    = pick[CW-1:0];
            win_wren_p0[t]  = core_wren[gnt_id_p0[t]];
            win_wdata_p0[t] = core_write_data[int'(gnt_id_p0[t])*DATA_WIDTH +: DATA_WIDTH];
            win_word_p0[t]  = bank_word[gnt_id_p0[t]];
        end
    end

    always_comb begin
        core_ready = '0;
        for (int t = 0; t < NT; t++) begin
            if (gnt_vld_p0[t]) core_ready[gnt_id_p0[t]] = 1'b1;
        end
    end

    always_comb begin
        device_write_en = gnt_vld_p0[DEV_T] && win_wren_p0[DEV_T];
        device_read_en  = gnt_vld_p0[DEV_T] && !win_wren_p0[DEV_T];
        device_addr     = '0;
        device_data_out = '0;
        device_core_id  = '0;
        if (gnt_vld_p0[DEV_T]) begin
            device_addr     = core_addr[int'(gnt_id_p0[DEV_T])*ADDR_WIDTH +: DEV_ADDR_WIDTH];
            device_data_out = win_wdata_p0[DEV_T];
            device_core_id  = gnt_id_p0[DEV_T];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < NT; t++) ptr[t] <= '0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (gnt_vld_p0[t]) ptr[t] <= rr_next(gnt_id_p0[t]);
            end
        end
    end

    // Stage p1: read return, one cycle after the granted edge.
    logic [NT-1:0]         rvld_p1;
    logic [CW-1:0]         rid_p1     [NT];
    logic [DATA_WIDTH-1:0] rd_data_p1 [NT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvld_p1 <= '0;
        end else begin
            rvld_p1 <= gnt_vld_p0 & ~win_wren_p0;
        end
    end

    always_ff @(posedge clk) begin
        for (int t = 0; t < NT; t++) begin
            if (gnt_vld_p0[t]) rid_p1[t] <= gnt_id_p0[t];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [WPB];
        logic [DATA_WIDTH-1:0] q_p1;

        always_ff @(posedge clk) begin
            if (gnt_vld_p0[b]) begin
                if (win_wren_p0[b]) mem[win_word_p0[b]] <= win_wdata_p0[b];
                else                q_p1 <= mem[win_word_p0[b]];
            end
        end

        assign rd_data_p1[b] = q_p1;
    end

    // The device presents its read data in the cycle after device_read_en.
    assign rd_data_p1[DEV_T] = device_data_in;

    always_comb begin
        core_rvalid    = '0;
        core_read_data = '0;
        for (int t = 0; t < NT; t++) begin
            if (rvld_p1[t]) begin
                core_rvalid[rid_p1[t]] = 1'b1;
                core_read_data[int'(rid_p1[t])*DATA_WIDTH +: DATA_WIDTH] = rd_data_p1[t];
            end
        end
    end

endmodule
